// File: rtl/sim_uart_xcvr.sv
// UART transceiver: TX/RX state machines at a fixed integer divisor,
// 2-flop RX synchroniser and a first-word-fall-through RX FIFO with sticky overflow.
module sim_uart_xcvr #(
   parameter int ClockFrequency = 50_000_000,
   parameter int BaudRate       = 115_200,
   parameter int DataBits       = 8,
   parameter bit ParityEn       = 1'b0,
   parameter bit ParityOdd      = 1'b0,
   parameter int RxFifoDepth    = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                active_i,
   input  logic                clear_i,
   output logic                tx_o,
   input  logic                rx_i,
   input  logic [DataBits-1:0] tx_data_i,
   input  logic                tx_valid_i,
   output logic                tx_ready_o,
   output logic [DataBits-1:0] rx_data_o,
   output logic                rx_valid_o,
   input  logic                rx_ready_i,
   output logic                rx_parity_err_o,
   output logic                rx_frame_err_o,
   output logic                rx_overflow_o
);

   localparam int Divisor = ClockFrequency / BaudRate;
   localparam int CntW    = $clog2(Divisor);
   localparam int PtrW    = $clog2(RxFifoDepth);
   localparam int EntW    = DataBits + 2;
   localparam logic [CntW-1:0] CntLast  = CntW'(Divisor - 1);
   localparam logic [CntW-1:0] CntHalf  = CntW'(Divisor / 2 - 1);
   localparam logic [2:0]      BitLast  = 3'(DataBits - 1);
   localparam logic [PtrW:0]   FifoFull = (PtrW+1)'(RxFifoDepth);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;

   tx_state_e           tx_state_q, tx_state_d;
   logic [CntW-1:0]     tx_cnt_q, tx_cnt_d;
   logic [2:0]          tx_bit_q, tx_bit_d;
   logic [DataBits-1:0] tx_sh_q, tx_sh_d;
   logic                tx_par_q, tx_par_d;
   logic                tx_line_q, tx_line_d;
   logic                tx_rdy_q, tx_rdy_d;

   rx_state_e           rx_state_q, rx_state_d;
   logic [CntW-1:0]     rx_cnt_q, rx_cnt_d;
   logic [2:0]          rx_bit_q, rx_bit_d;
   logic [DataBits-1:0] rx_sh_q, rx_sh_d;
   logic                rx_perr_q, rx_perr_d;
   logic                rx_meta_q, rx_sync_q;
   logic                push;
   logic [EntW-1:0]     push_ent;

   logic [EntW-1:0]     mem_q [RxFifoDepth];
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]       fifo_cnt_q, fifo_cnt_d;
   logic                ovf_q, ovf_d;
   logic                fifo_empty, fifo_full, pop, wr_en;
   logic [EntW-1:0]     head;

   // Ready is registered so it is low while in reset, then gated by active_i.
   assign tx_ready_o = tx_rdy_q & active_i;
   assign tx_o       = tx_line_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      tx_line_d  = tx_line_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_line_d = 1'b1;
            if (tx_valid_i && tx_ready_o) begin
               tx_state_d = TX_START;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_sh_d    = tx_data_i;
               tx_par_d   = ^tx_data_i ^ ParityOdd;
               tx_line_d  = 1'b0;
            end
         end
         default: begin
            if (tx_cnt_q != CntLast) begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end else begin
               tx_cnt_d = '0;
               case (tx_state_q)
                  TX_START: begin
                     tx_state_d = TX_DATA;
                     tx_line_d  = tx_sh_q[0];
                  end
                  TX_DATA: begin
                     if (tx_bit_q == BitLast) begin
                        tx_state_d = ParityEn ? TX_PARITY : TX_STOP;
                        tx_line_d  = ParityEn ? tx_par_q : 1'b1;
                     end else begin
                        tx_bit_d  = tx_bit_q + 1'b1;
                        tx_sh_d   = tx_sh_q >> 1;
                        tx_line_d = tx_sh_q[1];
                     end
                  end
                  TX_PARITY: begin
                     tx_state_d = TX_STOP;
                     tx_line_d  = 1'b1;
                  end
                  default: begin
                     tx_state_d = TX_IDLE;
                     tx_line_d  = 1'b1;
                  end
               endcase
            end
         end
      endcase
      if (!active_i) begin
         tx_state_d = TX_IDLE;
         tx_cnt_d   = '0;
         tx_bit_d   = '0;
         tx_line_d  = 1'b1;
      end
      tx_rdy_d = (tx_state_d == TX_IDLE);
   end

   // Samples land on bit midpoints: half a bit into START, then every full bit.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_perr_d  = rx_perr_q;
      push       = 1'b0;
      push_ent   = {~rx_sync_q, rx_perr_q, rx_sh_q};
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_sync_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt_q != CntHalf) begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end else begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_perr_d  = 1'b0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q != CntLast) begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end else begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_sync_q, rx_sh_q[DataBits-1:1]};
               if (rx_bit_q == BitLast) rx_state_d = ParityEn ? RX_PARITY : RX_STOP;
               else                     rx_bit_d   = rx_bit_q + 1'b1;
            end
         end
         RX_PARITY: begin
            if (rx_cnt_q != CntLast) begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end else begin
               rx_cnt_d   = '0;
               rx_perr_d  = rx_sync_q ^ (^rx_sh_q) ^ ParityOdd;
               rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q != CntLast) begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end else begin
               rx_cnt_d   = '0;
               push       = 1'b1;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_BREAK;
            end
         end
         default: begin
            if (rx_sync_q) rx_state_d = RX_IDLE;
         end
      endcase
      if (!active_i) begin
         rx_state_d = RX_IDLE;
         rx_cnt_d   = '0;
         rx_bit_d   = '0;
         push       = 1'b0;
      end
   end

   assign fifo_empty      = (fifo_cnt_q == '0);
   assign fifo_full       = (fifo_cnt_q == FifoFull);
   assign pop             = ~fifo_empty & rx_ready_i;
   assign wr_en           = push & (~fifo_full | pop);
   assign head            = mem_q[rd_ptr_q];
   assign rx_valid_o      = ~fifo_empty;
   assign rx_data_o       = fifo_empty ? '0 : head[DataBits-1:0];
   assign rx_parity_err_o = ~fifo_empty & head[DataBits];
   assign rx_frame_err_o  = ~fifo_empty & head[DataBits+1];
   assign rx_overflow_o   = ovf_q;

   always_comb begin
      wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (wr_en && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
      else if (!wr_en && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
      ovf_d = ovf_q;
      if (clear_i) ovf_d = 1'b0;
      if (push && fifo_full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
         tx_rdy_q   <= 1'b0;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_perr_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         ovf_q      <= 1'b0;
         for (int i = 0; i < RxFifoDepth; i++) mem_q[i] <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_line_q  <= tx_line_d;
         tx_rdy_q   <= tx_rdy_d;
         rx_meta_q  <= rx_i;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_perr_q  <= rx_perr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         ovf_q      <= ovf_d;
         if (wr_en) mem_q[wr_ptr_q] <= push_ent;
      end
   end

endmodule
